dac_sample_feeder: RTL and testbench
====================================

DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO depth in samples; SHALL be a power of two, 2 to 64.
REQ-002 Parameter DIV_W, default 16, meaning width of the sample-period divider.
REQ-003 Port CLK  input  1  meaning single block clock; all state SHALL change only on rising CLK.
REQ-004 Port RESET_N  input  1  meaning reset, synchronous, active-low.
REQ-005 Port EN  input  1  meaning playback enable.
REQ-006 Port DIV  input  DIV_W  meaning sample period minus one, in CLK cycles.
REQ-007 Port S_DATA  input  10  meaning unsigned sample from the producer.
REQ-008 Port S_VALID  input  1  meaning S_DATA valid.
REQ-009 Port S_READY  output  1  meaning FIFO can accept a sample this cycle.
REQ-010 Port D  output  10  meaning registered code to the DAC D[9:0] input.
REQ-011 Port D_STROBE  output  1  meaning one-cycle pulse, high in the cycle D takes a new popped value.
REQ-012 Port LEVEL  output  $clog2(DEPTH)+1  meaning current FIFO occupancy.
REQ-013 Port UNDERRUN  output  1  meaning sticky flag, set when a sample was due and the FIFO was empty.
REQ-014 Port UNDERRUN_CLR  input  1  meaning clears UNDERRUN.

Function
REQ-015 Push SHALL occur on a rising edge with S_VALID=1 and S_READY=1; S_READY SHALL equal (LEVEL != DEPTH), combinationally from registered state.
REQ-016 A pushed sample SHALL be poppable no earlier than the following edge; there is no fall-through.
REQ-017 Rate counter: while EN=1 it counts down; at count 0 a tick occurs and the counter reloads from DIV; while EN=0 the counter SHALL load DIV every cycle.
REQ-018 Ticks SHALL be DIV+1 cycles apart; DIV=0 SHALL tick every cycle while EN=1.
REQ-019 A DIV change SHALL take effect only at the next reload; the current count is not disturbed.
REQ-020 First tick after EN rises SHALL occur DIV+1 edges after the first edge sampled with EN=1.
REQ-021 On a tick with LEVEL>0: the FIFO head SHALL be popped into D, and D_STROBE SHALL be 1 for exactly the following cycle.
REQ-022 On a tick with LEVEL=0: D SHALL hold, D_STROBE SHALL stay 0, and UNDERRUN SHALL be set.
REQ-023 Push and pop on the same edge SHALL leave LEVEL unchanged and SHALL not corrupt data; a push into an empty FIFO on a tick edge is not popped that edge (underrun applies).
REQ-024 When full, S_READY=0; a pop on edge k SHALL make S_READY=1 in cycle k+1.
REQ-025 UNDERRUN_CLR=1 SHALL clear UNDERRUN, except that a same-edge underrun event SHALL win (flag stays 1).
REQ-026 EN=0 SHALL not flush the FIFO, SHALL hold D, and SHALL not block pushes.
REQ-027 Samples SHALL leave in strict arrival order; read/write pointers wrap modulo DEPTH with one extra bit distinguishing full from empty.

Reset
REQ-028 On an edge with RESET_N=0: FIFO empty (LEVEL=0), pointers 0, D=10'h200 (midscale), D_STROBE=0, UNDERRUN=0, counter loaded from DIV.
REQ-029 Reset asserted mid-playback SHALL discard all buffered samples; S_READY SHALL be 1 in the first cycle after reset releases.
REQ-030 FIFO storage array need not be reset; only pointers and outputs are.

Structure
REQ-031 Package dac_feeder_pkg SHALL hold DAC_W=10, MIDSCALE=10'h200, default DEPTH and DIV_W constants.
REQ-032 The FIFO SHALL be a sub-module dac_feeder_fifo (sync, single clock, push/pop/level/full/empty); the counter, D register and underrun logic live in the top.
REQ-033 No combinational path SHALL run from S_VALID to S_READY or to D.

Verification
REQ-034 Reset then EN=1, DIV=3, push 10'h000,10'h155,10'h3FF -> D updates at 4-cycle spacing to 000,155,3FF, each with one D_STROBE pulse; then UNDERRUN=1, D holds 3FF.
REQ-035 DIV=0, EN=1, S_VALID held high with incrementing data -> D increments by 1 every cycle, LEVEL stable, UNDERRUN stays 0.
REQ-036 EN=0, push 9 samples with DEPTH=8 -> S_READY drops after 8th, LEVEL=8, 9th held; EN=1, DIV=1 -> 9th accepted the cycle after first pop, all 9 out in order.
REQ-037 UNDERRUN set, UNDERRUN_CLR pulsed on an edge with a fresh underrun tick -> UNDERRUN stays 1; pulsed on a non-tick edge -> UNDERRUN=0.
REQ-038 RESET_N=0 for one edge with LEVEL=5 mid-playback -> LEVEL=0, D=10'h200, D_STROBE=0, UNDERRUN=0 next cycle.
REQ-039 DIV changed 7->2 mid-count -> current period completes at 8 cycles, subsequent ticks 3 cycles apart.

Source files
------------

// File: rtl/dac_feeder_pkg.sv
// Shared constants for the DAC sample feeder: DAC code width, reset code and default sizing.
package dac_feeder_pkg;

    localparam int               DAC_W     = 10;
    localparam logic [DAC_W-1:0] MIDSCALE  = 10'h200;
    localparam int               DEF_DEPTH = 8;
    localparam int               DEF_DIV_W = 16;

endpackage

// File: rtl/dac_feeder_fifo.sv
// Single-clock sample FIFO, no fall-through: a push becomes visible at the head one edge later.
// Pushes while full and pops while empty are ignored; level/full/empty come straight from the pointers.
module dac_feeder_fifo
    import dac_feeder_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int W     = DAC_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic [AW:0]  level_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra MSB on each pointer separates a full ring from an empty one.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Paces buffered samples out to a DAC at one sample per DIV+1 cycles; D/D_STROBE are registered.
// S_READY drops only when the FIFO is full; an empty FIFO at a sample tick raises sticky UNDERRUN.
module dac_sample_feeder
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     EN,
    input  logic [DIV_W-1:0]         DIV,
    input  logic [DAC_W-1:0]         S_DATA,
    input  logic                     S_VALID,
    output logic                     S_READY,
    output logic [DAC_W-1:0]         D,
    output logic                     D_STROBE,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     UNDERRUN,
    input  logic                     UNDERRUN_CLR
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DAC_W-1:0] d_q, d_d;
    logic             strobe_q, strobe_d;
    logic             underrun_q, underrun_d;

    logic             fifo_full, fifo_empty;
    logic [DAC_W-1:0] fifo_head;
    logic             push, tick, pop;

    assign S_READY = !fifo_full;
    assign push    = S_VALID && S_READY;
    assign tick    = EN && (cnt_q == '0);
    // Empty is judged on registered state, so a sample pushed on a tick edge waits for the next tick.
    assign pop     = tick && !fifo_empty;

    dac_feeder_fifo #(
        .DEPTH (DEPTH),
        .W     (DAC_W)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_n_i    (RESET_N),
        .push_i     (push),
        .push_dat_i (S_DATA),
        .pop_i      (pop),
        .pop_dat_o  (fifo_head),
        .level_o    (LEVEL),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        cnt_d      = cnt_q - CNT_ONE;
        d_d        = d_q;
        strobe_d   = pop;
        underrun_d = underrun_q;
        if (!EN || tick) cnt_d = DIV;
        if (pop) d_d = fifo_head;
        if (tick && fifo_empty) underrun_d = 1'b1;
        else if (UNDERRUN_CLR)  underrun_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_q      <= DIV;
            d_q        <= MIDSCALE;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            d_q        <= d_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    assign D        = d_q;
    assign D_STROBE = strobe_q;
    assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scenario bench for dac_sample_feeder: pushes are queued as expected output and matched on each D_STROBE.
module tb_dac_sample_feeder;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        EN;
    logic [15:0] DIV;
    logic [9:0]  S_DATA;
    logic        S_VALID;
    logic        S_READY;
    logic [9:0]  D;
    logic        D_STROBE;
    logic [3:0]  LEVEL;
    logic        UNDERRUN;
    logic        UNDERRUN_CLR;

    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  sb [$];
    logic [9:0]  exp_d;

    dac_sample_feeder #(.DEPTH(8), .DIV_W(16)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .EN           (EN),
        .DIV          (DIV),
        .S_DATA       (S_DATA),
        .S_VALID      (S_VALID),
        .S_READY      (S_READY),
        .D            (D),
        .D_STROBE     (D_STROBE),
        .LEVEL        (LEVEL),
        .UNDERRUN     (UNDERRUN),
        .UNDERRUN_CLR (UNDERRUN_CLR)
    );

    always #5 CLK = ~CLK;

    // Inputs change 2 time units after a rising edge, so at the falling edge they show what the next edge samples.
    always @(negedge CLK) begin
        if (D_STROBE) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_strobe_without_sample: D=%h, no sample expected", D);
            end else begin
                exp_d = sb.pop_front();
                if (D !== exp_d) begin
                    n_err++;
                    $display("FAIL sb_data: D=%h want %h", D, exp_d);
                end
            end
        end
        if (!RESET_N) sb.delete();
        else if (S_VALID && S_READY) sb.push_back(S_DATA);
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; EN = 1'b0; DIV = 16'd3; S_DATA = '0; S_VALID = 1'b0; UNDERRUN_CLR = 1'b0;
        step(); step();
        n_vec++; if (LEVEL !== 4'd0)     begin n_err++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
        n_vec++; if (D !== 10'h200)      begin n_err++; $display("FAIL reset_d: got %h want 200", D); end
        n_vec++; if (D_STROBE !== 1'b0)  begin n_err++; $display("FAIL reset_strobe: got %b want 0", D_STROBE); end
        n_vec++; if (UNDERRUN !== 1'b0)  begin n_err++; $display("FAIL reset_underrun: got %b want 0", UNDERRUN); end
        RESET_N = 1'b1;
        step();
        n_vec++; if (S_READY !== 1'b1)   begin n_err++; $display("FAIL reset_ready: got %b want 1", S_READY); end
    endtask

    task automatic test_basic();
        logic [9:0] vals [3] = '{10'h000, 10'h155, 10'h3FF};
        int st [3] = '{0, 0, 0};
        int n_str = 0;
        DIV = 16'd3; EN = 1'b0; S_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin S_DATA = vals[i]; step(); end
        S_VALID = 1'b0;
        n_vec++; if (LEVEL !== 4'd3) begin n_err++; $display("FAIL basic_level: got %0d want 3", LEVEL); end
        EN = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (D_STROBE) begin
                if (n_str < 3) st[n_str] = c;
                n_str++;
            end
            if (c == 15) begin
                n_vec++; if (UNDERRUN !== 1'b0) begin n_err++; $display("FAIL basic_no_early_underrun: got %b want 0", UNDERRUN); end
            end
        end
        n_vec++; if (n_str != 3) begin n_err++; $display("FAIL basic_strobe_count: got %0d want 3", n_str); end
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (st[k] != 4 * (k + 1)) begin n_err++; $display("FAIL basic_strobe_cycle%0d: got %0d want %0d", k, st[k], 4 * (k + 1)); end
        end
        n_vec++; if (UNDERRUN !== 1'b1) begin n_err++; $display("FAIL basic_underrun: got %b want 1", UNDERRUN); end
        n_vec++; if (D !== 10'h3FF)     begin n_err++; $display("FAIL basic_d_hold: got %h want 3ff", D); end
    endtask

    task automatic test_stream();
        EN = 1'b0; DIV = 16'd0; UNDERRUN_CLR = 1'b1; S_VALID = 1'b1; S_DATA = 10'h010;
        step();
        UNDERRUN_CLR = 1'b0;
        n_vec++; if (UNDERRUN !== 1'b0) begin n_err++; $display("FAIL stream_clr: got %b want 0", UNDERRUN); end
        n_vec++; if (LEVEL !== 4'd1)    begin n_err++; $display("FAIL stream_prefill: got %0d want 1", LEVEL); end
        EN = 1'b1; S_DATA = 10'h011;
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++; if (D_STROBE !== 1'b1) begin n_err++; $display("FAIL stream_strobe%0d: got %b want 1", i, D_STROBE); end
            n_vec++; if (D !== 10'h010 + 10'(i)) begin n_err++; $display("FAIL stream_d%0d: got %h want %h", i, D, 10'h010 + 10'(i)); end
            n_vec++; if (LEVEL !== 4'd1)    begin n_err++; $display("FAIL stream_level%0d: got %0d want 1", i, LEVEL); end
            n_vec++; if (UNDERRUN !== 1'b0) begin n_err++; $display("FAIL stream_underrun%0d: got %b want 0", i, UNDERRUN); end
            S_DATA = S_DATA + 10'd1;
        end
        S_VALID = 1'b0;
        step(); step();
        n_vec++; if (UNDERRUN !== 1'b1) begin n_err++; $display("FAIL stream_drain_underrun: got %b want 1", UNDERRUN); end
        n_vec++; if (LEVEL !== 4'd0)    begin n_err++; $display("FAIL stream_drain_level: got %0d want 0", LEVEL); end
    endtask

    task automatic test_underrun_clr();
        UNDERRUN_CLR = 1'b1;
        step();
        n_vec++; if (UNDERRUN !== 1'b1) begin n_err++; $display("FAIL clr_vs_tick: got %b want 1", UNDERRUN); end
        EN = 1'b0;
        step();
        n_vec++; if (UNDERRUN !== 1'b0) begin n_err++; $display("FAIL clr_no_tick: got %b want 0", UNDERRUN); end
        UNDERRUN_CLR = 1'b0;
        step();
        n_vec++; if (UNDERRUN !== 1'b0) begin n_err++; $display("FAIL clr_stays: got %b want 0", UNDERRUN); end
    endtask

    task automatic test_full();
        int n_str = 0;
        EN = 1'b0; DIV = 16'd1; S_VALID = 1'b1;
        for (int i = 0; i < 8; i++) begin S_DATA = 10'h100 + 10'(i); step(); end
        n_vec++; if (LEVEL !== 4'd8)   begin n_err++; $display("FAIL full_level: got %0d want 8", LEVEL); end
        n_vec++; if (S_READY !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", S_READY); end
        S_DATA = 10'h108;
        step(); step();
        n_vec++; if (LEVEL !== 4'd8)   begin n_err++; $display("FAIL full_hold_level: got %0d want 8", LEVEL); end
        n_vec++; if (S_READY !== 1'b0) begin n_err++; $display("FAIL full_hold_ready: got %b want 0", S_READY); end
        EN = 1'b1;
        step();
        n_vec++; if (D_STROBE !== 1'b0) begin n_err++; $display("FAIL full_first_edge_strobe: got %b want 0", D_STROBE); end
        step();
        n_vec++; if (D_STROBE !== 1'b1) begin n_err++; $display("FAIL full_first_pop: got %b want 1", D_STROBE); end
        n_vec++; if (S_READY !== 1'b1)  begin n_err++; $display("FAIL full_ready_after_pop: got %b want 1", S_READY); end
        if (D_STROBE) n_str++;
        step();
        S_VALID = 1'b0;
        n_vec++; if (LEVEL !== 4'd8)    begin n_err++; $display("FAIL full_ninth_accepted: got %0d want 8", LEVEL); end
        for (int c = 0; c < 40 && n_str < 9; c++) begin
            step();
            if (D_STROBE) n_str++;
        end
        EN = 1'b0;
        n_vec++; if (n_str != 9)     begin n_err++; $display("FAIL full_drain_count: got %0d want 9", n_str); end
        n_vec++; if (LEVEL !== 4'd0) begin n_err++; $display("FAIL full_drain_level: got %0d want 0", LEVEL); end
    endtask

    task automatic test_div_change();
        int st [3] = '{0, 0, 0};
        int n_str = 0;
        EN = 1'b0; DIV = 16'd7; S_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin S_DATA = 10'h2A0 + 10'(i); step(); end
        S_VALID = 1'b0;
        EN = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 4) DIV = 16'd2;
            step();
            if (D_STROBE) begin
                if (n_str < 3) st[n_str] = c;
                n_str++;
            end
        end
        EN = 1'b0;
        n_vec++; if (st[0] != 8)  begin n_err++; $display("FAIL div_first_tick: got %0d want 8", st[0]); end
        n_vec++; if (st[1] != 11) begin n_err++; $display("FAIL div_second_tick: got %0d want 11", st[1]); end
        n_vec++; if (st[2] != 14) begin n_err++; $display("FAIL div_third_tick: got %0d want 14", st[2]); end
        n_vec++; if (n_str != 4)  begin n_err++; $display("FAIL div_strobe_count: got %0d want 4", n_str); end
    endtask

    task automatic test_reset_mid();
        int c;
        int n_str = 0;
        EN = 1'b0; DIV = 16'd2; S_VALID = 1'b1;
        for (int i = 0; i < 6; i++) begin S_DATA = 10'h050 + 10'(i); step(); end
        S_VALID = 1'b0;
        EN = 1'b1;
        c = 0;
        while (!D_STROBE && c < 10) begin step(); c++; end
        n_vec++; if (D_STROBE !== 1'b1) begin n_err++; $display("FAIL rst_mid_no_pop: got %b want 1", D_STROBE); end
        n_vec++; if (LEVEL !== 4'd5)    begin n_err++; $display("FAIL rst_mid_level_before: got %0d want 5", LEVEL); end
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        n_vec++; if (LEVEL !== 4'd0)    begin n_err++; $display("FAIL rst_mid_level: got %0d want 0", LEVEL); end
        n_vec++; if (D !== 10'h200)     begin n_err++; $display("FAIL rst_mid_d: got %h want 200", D); end
        n_vec++; if (D_STROBE !== 1'b0) begin n_err++; $display("FAIL rst_mid_strobe: got %b want 0", D_STROBE); end
        n_vec++; if (UNDERRUN !== 1'b0) begin n_err++; $display("FAIL rst_mid_underrun: got %b want 0", UNDERRUN); end
        n_vec++; if (S_READY !== 1'b1)  begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", S_READY); end
        for (int k = 0; k < 4; k++) begin
            step();
            if (D_STROBE) n_str++;
        end
        n_vec++; if (n_str != 0)        begin n_err++; $display("FAIL rst_mid_discard: got %0d strobes want 0", n_str); end
        n_vec++; if (UNDERRUN !== 1'b1) begin n_err++; $display("FAIL rst_mid_post_underrun: got %b want 1", UNDERRUN); end
        EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_underrun_clr();
        test_full();
        test_div_change();
        test_reset_mid();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
